// File: rtl/pass_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pass_arbiter
// Purpose  : Round-robin arbiter and sequencer that shares a single registered
//            pass-gate evaluation unit (f = ~x & y) among N requesters.
//            One transaction is serviced at a time:
//              IDLE -> grant + operand capture -> EVAL -> result -> RESP
//            The result leaves on a valid/ready channel, tagged with the id
//            of the requester that owns it.
// Ports    : clk          rising-edge clock
//            rst_n        synchronous active-low reset
//            i_req[N]     per-requester request
//            i_x[N]       per-requester x operand
//            i_y[N]       per-requester y operand
//            o_gnt[N]     one-hot grant, one cycle per transaction
//            o_res_valid  result available
//            o_res_id     owner of the result
//            o_res_f      result, ~x & y of the granted requester
//            i_res_ready  consumer accepts the result
//            o_busy       high whenever the sequencer is not idle
// Revision : 1.0 - initial release
// ============================================================================
module pass_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   i_req,
  input  logic [N-1:0]   i_x,
  input  logic [N-1:0]   i_y,
  output logic [N-1:0]   o_gnt,
  output logic           o_res_valid,
  output logic [IDW-1:0] o_res_id,
  output logic           o_res_f,
  input  logic           i_res_ready,
  output logic           o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Registered state
  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic             r_xl;
  logic             r_yl;
  logic [N-1:0]     r_gnt;
  logic             r_valid;
  logic [IDW-1:0]   r_id;
  logic             r_f;
  logic             r_busy;

  // Next-state values
  state_t           w_state_nxt;
  logic [IDW-1:0]   w_ptr_nxt;
  logic             w_xl_nxt;
  logic             w_yl_nxt;
  logic [N-1:0]     w_gnt_nxt;
  logic             w_valid_nxt;
  logic [IDW-1:0]   w_id_nxt;
  logic             w_f_nxt;
  logic             w_busy_nxt;

  // Arbitration
  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic [IDW:0]     w_sum;
  logic [IDW-1:0]   w_idx;

  // Scan requesters starting at r_ptr and wrapping modulo N. The sum is one
  // bit wider than the pointer so ptr+k never overflows before the wrap test,
  // which keeps the index below N for non-power-of-2 N.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(N)) begin
        w_sum = w_sum - (IDW+1)'(N);
      end
      w_idx = w_sum[IDW-1:0];
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_xl_nxt    = r_xl;
    w_yl_nxt    = r_yl;
    w_gnt_nxt   = '0;
    w_valid_nxt = r_valid;
    w_id_nxt    = r_id;
    w_f_nxt     = r_f;
    w_busy_nxt  = r_busy;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_nxt   = N'(1) << w_win;
          w_xl_nxt    = i_x[w_win];
          w_yl_nxt    = i_y[w_win];
          w_id_nxt    = w_win;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_EVAL;
        end
      end

      S_EVAL: begin
        w_f_nxt     = ~r_xl & r_yl;
        w_valid_nxt = 1'b1;
        // r_id still holds the winner; advance past it with explicit wrap.
        w_ptr_nxt   = (r_id == IDW'(N-1)) ? '0 : r_id + 1'b1;
        w_state_nxt = S_RESP;
      end

      S_RESP: begin
        // Requests are not looked at here, so backpressure never leaks a grant.
        if (i_res_ready) begin
          w_valid_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_xl    <= 1'b0;
      r_yl    <= 1'b0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_f     <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_xl    <= w_xl_nxt;
      r_yl    <= w_yl_nxt;
      r_gnt   <= w_gnt_nxt;
      r_valid <= w_valid_nxt;
      r_id    <= w_id_nxt;
      r_f     <= w_f_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_res_valid = r_valid;
  assign o_res_id    = r_id;
  assign o_res_f     = r_f;
  assign o_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pass_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pass_arbiter
// Purpose  : Self-checking bench for pass_arbiter. Two instances are used:
//            N=4 for most scenarios and N=3 for the non-power-of-2 wrap.
//            Expected results {id, f} are queued when stimulus is driven and
//            popped when the DUT presents the result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pass_arbiter;

  logic       clk;
  logic       rst_n;

  logic [3:0] req4, x4, y4, gnt4;
  logic       rdy4, valid4, f4, busy4;
  logic [1:0] id4;

  logic [2:0] req3, x3, y3, gnt3;
  logic       rdy3, valid3, f3, busy3;
  logic [1:0] id3;

  int         n_cmp;
  int         n_err;
  logic [2:0] q4[$];
  logic [2:0] q3[$];
  logic [2:0] e;

  pass_arbiter #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_req(req4), .i_x(x4), .i_y(y4),
    .o_gnt(gnt4), .o_res_valid(valid4), .o_res_id(id4), .o_res_f(f4),
    .i_res_ready(rdy4), .o_busy(busy4)
  );

  pass_arbiter #(.N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_req(req3), .i_x(x3), .i_y(y3),
    .o_gnt(gnt3), .o_res_valid(valid3), .o_res_id(id3), .o_res_f(f3),
    .i_res_ready(rdy3), .o_busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled and inputs driven 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req4 = 4'hF; x4 = 4'h0; y4 = 4'h0; rdy4 = 1'b1;
    req3 = 3'h0; x3 = 3'h0; y3 = 3'h0; rdy3 = 1'b1;
    tick(); tick();
    n_cmp++; if (gnt4 !== 4'b0000) begin n_err++; $display("FAIL rst_gnt got=%b exp=0000", gnt4); end
    n_cmp++; if (valid4 !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", valid4); end
    n_cmp++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy4); end
    n_cmp++; if (id4 !== 2'd0) begin n_err++; $display("FAIL rst_id got=%0d exp=0", id4); end
    n_cmp++; if (f4 !== 1'b0) begin n_err++; $display("FAIL rst_f got=%b exp=0", f4); end
    rst_n = 1'b1;
    q4.push_back({2'd0, ~x4[0] & y4[0]});
    tick();
    n_cmp++; if (gnt4 !== 4'b0001) begin n_err++; $display("FAIL rst_first_gnt got=%b exp=0001", gnt4); end
    n_cmp++; if (busy4 !== 1'b1) begin n_err++; $display("FAIL rst_first_busy got=%b exp=1", busy4); end
    req4 = 4'h0;
    tick();
    n_cmp++; if (valid4 !== 1'b1) begin n_err++; $display("FAIL rst_first_valid got=%b exp=1", valid4); end
    if (q4.size() == 0) begin n_err++; $display("FAIL rst_sb_empty no expected entry"); end
    else begin
      e = q4.pop_front();
      n_cmp++; if ({id4, f4} !== e) begin n_err++; $display("FAIL rst_first_res got=%0d/%b exp=%0d/%b", id4, f4, e[2:1], e[0]); end
    end
    tick();
    n_cmp++; if ({valid4, busy4} !== 2'b00) begin n_err++; $display("FAIL rst_first_done valid/busy got=%b exp=00", {valid4, busy4}); end
  endtask

  task automatic test_single();
    req4 = 4'b0010; x4 = 4'b0000; y4 = 4'b0010; rdy4 = 1'b1;
    q4.push_back({2'd1, ~x4[1] & y4[1]});
    tick();
    n_cmp++; if (gnt4 !== 4'b0010) begin n_err++; $display("FAIL single_gnt got=%b exp=0010", gnt4); end
    n_cmp++; if (valid4 !== 1'b0) begin n_err++; $display("FAIL single_early_valid got=%b exp=0", valid4); end
    req4 = 4'b0000;
    tick();
    n_cmp++; if (gnt4 !== 4'b0000) begin n_err++; $display("FAIL single_gnt_drop got=%b exp=0000", gnt4); end
    n_cmp++; if (valid4 !== 1'b1) begin n_err++; $display("FAIL single_valid got=%b exp=1", valid4); end
    if (q4.size() == 0) begin n_err++; $display("FAIL single_sb_empty no expected entry"); end
    else begin
      e = q4.pop_front();
      n_cmp++; if ({id4, f4} !== e) begin n_err++; $display("FAIL single_res got=%0d/%b exp=%0d/%b", id4, f4, e[2:1], e[0]); end
    end
    tick();
    n_cmp++; if ({valid4, busy4} !== 2'b00) begin n_err++; $display("FAIL single_done valid/busy got=%b exp=00", {valid4, busy4}); end
  endtask

  task automatic test_truth_table();
    logic [1:0] v;
    for (int t = 0; t < 4; t++) begin
      v    = 2'(t);
      x4   = {1'b0, v[1], 2'b00};
      y4   = {1'b0, v[0], 2'b00};
      req4 = 4'b0100; rdy4 = 1'b1;
      q4.push_back({2'd2, ~v[1] & v[0]});
      tick();
      n_cmp++; if (gnt4 !== 4'b0100) begin n_err++; $display("FAIL tt%0d_gnt got=%b exp=0100", t, gnt4); end
      req4 = 4'b0000;
      tick();
      n_cmp++; if (valid4 !== 1'b1) begin n_err++; $display("FAIL tt%0d_valid got=%b exp=1", t, valid4); end
      if (q4.size() == 0) begin n_err++; $display("FAIL tt%0d_sb_empty no expected entry", t); end
      else begin
        e = q4.pop_front();
        n_cmp++; if ({id4, f4} !== e) begin n_err++; $display("FAIL tt%0d_res got=%0d/%b exp=%0d/%b", t, id4, f4, e[2:1], e[0]); end
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int seq4[5] = '{0, 1, 2, 3, 0};
    int seq3[4] = '{0, 1, 2, 0};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req4 = 4'hF; x4 = 4'b0101; y4 = 4'b0011; rdy4 = 1'b1;
    for (int t = 0; t < 5; t++) q4.push_back({2'(seq4[t]), ~x4[seq4[t]] & y4[seq4[t]]});
    for (int t = 0; t < 5; t++) begin
      tick();
      n_cmp++; if (gnt4 !== (4'b0001 << seq4[t])) begin n_err++; $display("FAIL rr4_%0d_gnt got=%b exp=%b", t, gnt4, 4'b0001 << seq4[t]); end
      if (t == 4) req4 = 4'h0;
      tick();
      n_cmp++; if ({valid4, gnt4} !== 5'b1_0000) begin n_err++; $display("FAIL rr4_%0d_valid/gnt got=%b exp=10000", t, {valid4, gnt4}); end
      if (q4.size() == 0) begin n_err++; $display("FAIL rr4_%0d_sb_empty no expected entry", t); end
      else begin
        e = q4.pop_front();
        n_cmp++; if ({id4, f4} !== e) begin n_err++; $display("FAIL rr4_%0d_res got=%0d/%b exp=%0d/%b", t, id4, f4, e[2:1], e[0]); end
      end
      tick();
    end
    req3 = 3'b111; x3 = 3'b010; y3 = 3'b111; rdy3 = 1'b1;
    for (int t = 0; t < 4; t++) q3.push_back({2'(seq3[t]), ~x3[seq3[t]] & y3[seq3[t]]});
    for (int t = 0; t < 4; t++) begin
      tick();
      n_cmp++; if (gnt3 !== (3'b001 << seq3[t])) begin n_err++; $display("FAIL rr3_%0d_gnt got=%b exp=%b", t, gnt3, 3'b001 << seq3[t]); end
      if (t == 3) req3 = 3'h0;
      tick();
      n_cmp++; if (valid3 !== 1'b1) begin n_err++; $display("FAIL rr3_%0d_valid got=%b exp=1", t, valid3); end
      if (q3.size() == 0) begin n_err++; $display("FAIL rr3_%0d_sb_empty no expected entry", t); end
      else begin
        e = q3.pop_front();
        n_cmp++; if ({id3, f3} !== e) begin n_err++; $display("FAIL rr3_%0d_res got=%0d/%b exp=%0d/%b", t, id3, f3, e[2:1], e[0]); end
      end
      tick();
    end
  endtask

  // Operands start at x=1,y=1 (f=0); x drops to 0 after the grant, which
  // would yield f=1 if the operand were not captured at the grant edge.
  task automatic test_backpressure();
    req4 = 4'b0001; x4 = 4'b0001; y4 = 4'b0001; rdy4 = 1'b1;
    q4.push_back({2'd0, ~x4[0] & y4[0]});
    tick();
    n_cmp++; if (gnt4 !== 4'b0001) begin n_err++; $display("FAIL bp_gnt got=%b exp=0001", gnt4); end
    x4 = 4'b0000; req4 = 4'b0000; rdy4 = 1'b0;
    tick();
    n_cmp++; if (valid4 !== 1'b1) begin n_err++; $display("FAIL bp_valid got=%b exp=1", valid4); end
    if (q4.size() == 0) begin n_err++; $display("FAIL bp_sb_empty no expected entry"); e = 3'b000; end
    else begin
      e = q4.pop_front();
      n_cmp++; if ({id4, f4} !== e) begin n_err++; $display("FAIL bp_res got=%0d/%b exp=%0d/%b", id4, f4, e[2:1], e[0]); end
    end
    req4 = 4'b0010;
    for (int t = 0; t < 5; t++) begin
      tick();
      n_cmp++; if ({valid4, id4, f4} !== {1'b1, e}) begin n_err++; $display("FAIL bp_hold%0d valid/id/f got=%b/%0d/%b exp=1/%0d/%b", t, valid4, id4, f4, e[2:1], e[0]); end
      n_cmp++; if ({gnt4, busy4} !== 5'b0000_1) begin n_err++; $display("FAIL bp_hold%0d gnt/busy got=%b/%b exp=0000/1", t, gnt4, busy4); end
    end
    rdy4 = 1'b1; req4 = 4'b0000;
    tick();
    n_cmp++; if ({valid4, busy4} !== 2'b00) begin n_err++; $display("FAIL bp_release valid/busy got=%b exp=00", {valid4, busy4}); end
  endtask

  task automatic test_mid_reset();
    req4 = 4'b0100; x4 = 4'b0000; y4 = 4'b0100; rdy4 = 1'b0;
    tick();
    n_cmp++; if (gnt4 !== 4'b0100) begin n_err++; $display("FAIL mr_gnt got=%b exp=0100", gnt4); end
    req4 = 4'b0000;
    tick(); tick();
    n_cmp++; if (valid4 !== 1'b1) begin n_err++; $display("FAIL mr_resp_valid got=%b exp=1", valid4); end
    rst_n = 1'b0;
    tick();
    n_cmp++; if ({valid4, busy4, gnt4} !== 6'b0) begin n_err++; $display("FAIL mr_after_rst valid/busy/gnt got=%b exp=000000", {valid4, busy4, gnt4}); end
    rst_n = 1'b1; rdy4 = 1'b1;
    tick();
    n_cmp++; if ({valid4, busy4} !== 2'b00) begin n_err++; $display("FAIL mr_no_reappear valid/busy got=%b exp=00", {valid4, busy4}); end
    // Pointer was 3 before the reset; requester 1 must now win over 3.
    req4 = 4'b1010; x4 = 4'b0000; y4 = 4'b1010;
    q4.push_back({2'd1, ~x4[1] & y4[1]});
    tick();
    n_cmp++; if (gnt4 !== 4'b0010) begin n_err++; $display("FAIL mr_next_gnt got=%b exp=0010", gnt4); end
    req4 = 4'b0000;
    tick();
    n_cmp++; if (valid4 !== 1'b1) begin n_err++; $display("FAIL mr_next_valid got=%b exp=1", valid4); end
    if (q4.size() == 0) begin n_err++; $display("FAIL mr_sb_empty no expected entry"); end
    else begin
      e = q4.pop_front();
      n_cmp++; if ({id4, f4} !== e) begin n_err++; $display("FAIL mr_next_res got=%0d/%b exp=%0d/%b", id4, f4, e[2:1], e[0]); end
    end
    tick();
    n_cmp++; if ((q4.size() + q3.size()) !== 0) begin n_err++; $display("FAIL sb_leftover got=%0d exp=0", q4.size() + q3.size()); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_truth_table();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
